cmp_search_ctrl: RTL and testbench

// - Initiator that drives a magnitude comparator to find an unknown value (binary search).
// - Issues probe values; the external 4-/8-bit magnitude comparator checks target (a) against

---
 rtl/cmp_search_pkg.sv | 26 ++
 rtl/cmp_search_bound.sv | 40 ++++
 rtl/cmp_search_ctrl.sv | 135 +++++++++++++
 tb/tb_cmp_search_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/cmp_search_pkg.sv
// Shared encodings for the comparator-driven binary search controller.
// Holds state encodings, the default width and comparator result codes.
package cmp_search_pkg;

   localparam int DEF_WIDTH = 8;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_PROBE = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      PROBE = ST_PROBE,
      DONE  = ST_DONE
   } state_t;

   // Comparator result as {gt, eq, lt}
   localparam logic [2:0] CMP_GT = 3'b100;
   localparam logic [2:0] CMP_EQ = 3'b010;
   localparam logic [2:0] CMP_LT = 3'b001;

   function automatic logic res_legal(input logic [2:0] res);
      return (res == CMP_GT) || (res == CMP_EQ) || (res == CMP_LT);
   endfunction

endpackage

// File: rtl/cmp_search_bound.sv
// Combinational next-bound update for one search step; zero latency, no flow control.
// Flags an empty range, including the mid==0 & lt underflow case.
module cmp_search_bound
   import cmp_search_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [WIDTH:0] lo,
   input  logic [WIDTH:0] hi,
   input  logic [WIDTH:0] mid,
   input  logic           gt,
   input  logic           lt,
   output logic [WIDTH:0] next_lo,
   output logic [WIDTH:0] next_hi,
   output logic           empty
);

   localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

   always_comb begin
      next_lo = lo;
      next_hi = hi;
      empty   = 1'b0;
      if (gt) begin
         next_lo = mid + ONE;
      end
      // hi would go negative; treat as empty rather than letting it wrap
      if (lt) begin
         if (mid == '0) begin
            empty = 1'b1;
         end else begin
            next_hi = mid - ONE;
         end
      end
      if (next_lo > next_hi) begin
         empty = 1'b1;
      end
   end

endmodule

// File: rtl/cmp_search_ctrl.sv
// Binary-search initiator driving an external magnitude comparator; first probe the cycle after start.
// Probe held stable until cmp_valid; one probe per cycle when cmp_valid is tied high.
module cmp_search_ctrl
   import cmp_search_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic [WIDTH-1:0] probe,
   output logic             probe_valid,
   input  logic             cmp_valid,
   input  logic             cmp_gt,
   input  logic             cmp_eq,
   input  logic             cmp_lt,
   output logic             busy,
   output logic             done,
   output logic             found,
   output logic             err,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       probes
);

   state_t           state, state_nxt;
   logic [WIDTH:0]   lo, hi, lo_nxt, hi_nxt;
   logic [WIDTH:0]   mid;
   logic [WIDTH:0]   bnd_lo, bnd_hi;
   logic             bnd_empty;
   logic [3:0]       probes_nxt;
   logic             found_nxt, err_nxt;
   logic [WIDTH-1:0] result_nxt;
   logic [2:0]       res;

   // Overflow-free midpoint: floor((lo+hi)/2) without a wider sum
   assign mid = lo + ((hi - lo) >> 1);
   assign res = {cmp_gt, cmp_eq, cmp_lt};

   cmp_search_bound #(
      .WIDTH (WIDTH)
   ) u_bound (
      .lo      (lo),
      .hi      (hi),
      .mid     (mid),
      .gt      (cmp_gt),
      .lt      (cmp_lt),
      .next_lo (bnd_lo),
      .next_hi (bnd_hi),
      .empty   (bnd_empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      lo_nxt      = lo;
      hi_nxt      = hi;
      probes_nxt  = probes;
      found_nxt   = found;
      err_nxt     = err;
      result_nxt  = result;
      probe       = '0;
      probe_valid = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               lo_nxt     = '0;
               hi_nxt     = {1'b0, {WIDTH{1'b1}}};
               probes_nxt = '0;
               found_nxt  = 1'b0;
               err_nxt    = 1'b0;
               state_nxt  = PROBE;
            end
         end
         PROBE: begin
            probe       = mid[WIDTH-1:0];
            probe_valid = 1'b1;
            busy        = 1'b1;
            if (cmp_valid) begin
               probes_nxt = (probes == 4'hF) ? probes : probes + 4'd1;
               if (!res_legal(res)) begin
                  err_nxt    = 1'b1;
                  result_nxt = mid[WIDTH-1:0];
                  state_nxt  = DONE;
               end else if (res == CMP_EQ) begin
                  found_nxt  = 1'b1;
                  result_nxt = mid[WIDTH-1:0];
                  state_nxt  = DONE;
               end else if (bnd_empty) begin
                  err_nxt    = 1'b1;
                  result_nxt = mid[WIDTH-1:0];
                  state_nxt  = DONE;
               end else begin
                  lo_nxt = bnd_lo;
                  hi_nxt = bnd_hi;
               end
            end
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lo     <= '0;
         hi     <= '0;
         probes <= '0;
         found  <= 1'b0;
         err    <= 1'b0;
         result <= '0;
      end else begin
         lo     <= lo_nxt;
         hi     <= hi_nxt;
         probes <= probes_nxt;
         found  <= found_nxt;
         err    <= err_nxt;
         result <= result_nxt;
      end
   end

endmodule

// File: tb/tb_cmp_search_ctrl.sv
// Directed bench for cmp_search_ctrl with a behavioural comparator model.
module tb_cmp_search_ctrl;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [7:0] probe;
   logic       probe_valid;
   logic       cmp_valid;
   logic       cmp_gt, cmp_eq, cmp_lt;
   logic       busy, done, found, err;
   logic [7:0] result;
   logic [3:0] probes;

   logic [7:0] target;
   logic [1:0] mode;      // 0 true compare, 1 always lt, 2 gt+eq illegal
   logic       delay;
   int         wait_cnt;
   int         vectors;
   int         miscompares;
   logic [7:0] obs_q[$];
   logic [7:0] exp_q[$];
   int         cyc;
   logic       stable_ok;
   logic       no_done;

   cmp_search_ctrl #(.WIDTH(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .probe       (probe),
      .probe_valid (probe_valid),
      .cmp_valid   (cmp_valid),
      .cmp_gt      (cmp_gt),
      .cmp_eq      (cmp_eq),
      .cmp_lt      (cmp_lt),
      .busy        (busy),
      .done        (done),
      .found       (found),
      .err         (err),
      .result      (result),
      .probes      (probes)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign cmp_valid = delay ? (wait_cnt == 3) : 1'b1;
   assign cmp_gt = (mode == 2'd0) ? (target > probe)  : (mode == 2'd2);
   assign cmp_eq = (mode == 2'd0) ? (target == probe) : (mode == 2'd2);
   assign cmp_lt = (mode == 2'd0) ? (target < probe)  : (mode == 2'd1);

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n || !probe_valid || cmp_valid) wait_cnt <= 0;
      else wait_cnt <= wait_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_seq(input string tag);
      logic [31:0] o;
      check({tag, "_count"}, obs_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         o = (i < obs_q.size()) ? {24'd0, obs_q[i]} : 32'hxxxx_xxxx;
         check($sformatf("%s_probe%0d", tag, i), o, {24'd0, exp_q[i]});
      end
   endtask

   // Pulse start, then follow the search to done, recording each compared probe.
   task automatic run(input logic [7:0] tgt, input logic [1:0] md, input logic dly,
                      input logic poke, input string tag);
      logic       prev_hold;
      logic [7:0] prev_probe;
      target = tgt; mode = md; delay = dly;
      obs_q.delete();
      stable_ok = 1'b1;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      check({tag, "_busy"}, busy, 1'b1);
      cyc = 0;
      while (!done && cyc < 200) begin
         if (probe_valid && cmp_valid) obs_q.push_back(probe);
         prev_hold  = probe_valid && !cmp_valid;
         prev_probe = probe;
         @(negedge clk);
         cyc++;
         if (poke) start = (cyc == 1);
         if (prev_hold && (!probe_valid || probe !== prev_probe)) stable_ok = 1'b0;
      end
      start = 1'b0;
      check({tag, "_done_seen"}, done, 1'b1);
   endtask

   initial begin
      vectors = 0; miscompares = 0;
      rst_n = 1'b0; start = 1'b0; target = 8'h00; mode = 2'd0; delay = 1'b0;
      @(negedge clk);
      check("rst_probe", probe, 8'h00);
      check("rst_probe_valid", probe_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_found", found, 1'b0);
      check("rst_err", err, 1'b0);
      check("rst_result", result, 8'h00);
      check("rst_probes", probes, 4'h0);
      rst_n = 1'b1;
      @(negedge clk);

      // T1
      run(8'h5A, 2'd0, 1'b0, 1'b0, "t1");
      exp_q = '{8'h7F, 8'h3F, 8'h5F, 8'h4F, 8'h57, 8'h5B, 8'h59, 8'h5A};
      check_seq("t1");
      check("t1_latency", cyc, 8);
      check("t1_found", found, 1'b1);
      check("t1_err", err, 1'b0);
      check("t1_result", result, 8'h5A);
      check("t1_probes", probes, 4'd8);
      check("t1_busy_done", busy, 1'b0);
      check("t1_pv_done", probe_valid, 1'b0);
      @(negedge clk);
      check("t1_done_pulse", done, 1'b0);
      check("t1_found_held", found, 1'b1);

      // T2 low and high extremes
      run(8'h00, 2'd0, 1'b0, 1'b0, "t2lo");
      exp_q = '{8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01, 8'h00};
      check_seq("t2lo");
      check("t2lo_found", found, 1'b1);
      check("t2lo_result", result, 8'h00);
      check("t2lo_probes", probes, 4'd8);
      run(8'hFF, 2'd0, 1'b0, 1'b0, "t2hi");
      exp_q = '{8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE, 8'hFF};
      check_seq("t2hi");
      check("t2hi_found", found, 1'b1);
      check("t2hi_err", err, 1'b0);
      check("t2hi_result", result, 8'hFF);
      check("t2hi_probes", probes, 4'd9);

      // T3 comparator stuck at lt
      run(8'h00, 2'd1, 1'b0, 1'b0, "t3");
      check("t3_err", err, 1'b1);
      check("t3_found", found, 1'b0);
      check("t3_probes", probes, 4'd8);
      check("t3_result", result, 8'h00);

      // T4 slow comparator
      run(8'h5A, 2'd0, 1'b1, 1'b0, "t4");
      exp_q = '{8'h7F, 8'h3F, 8'h5F, 8'h4F, 8'h57, 8'h5B, 8'h59, 8'h5A};
      check_seq("t4");
      check("t4_latency", cyc, 32);
      check("t4_stable", stable_ok, 1'b1);
      check("t4_found", found, 1'b1);
      check("t4_result", result, 8'h5A);

      // T5 illegal result, start pulsed while busy and during done
      run(8'h00, 2'd2, 1'b1, 1'b1, "t5");
      check("t5_err", err, 1'b1);
      check("t5_found", found, 1'b0);
      check("t5_result", result, 8'h7F);
      check("t5_probes", probes, 4'd1);
      check("t5_stable", stable_ok, 1'b1);
      start = 1'b1;
      @(negedge clk) start = 1'b0;
      check("t5_start_in_done_busy", busy, 1'b0);
      check("t5_start_in_done_pv", probe_valid, 1'b0);
      @(negedge clk);
      check("t5_still_idle", busy, 1'b0);

      // T6 reset during the 4th probe
      target = 8'h5A; mode = 2'd0; delay = 1'b1;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      cyc = 0;
      while (!(probe_valid && probe == 8'h4F) && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      check("t6_reached_4th", probe, 8'h4F);
      #2 rst_n = 1'b0;
      #1;
      check("t6_probe", probe, 8'h00);
      check("t6_probe_valid", probe_valid, 1'b0);
      check("t6_busy", busy, 1'b0);
      check("t6_done", done, 1'b0);
      check("t6_found", found, 1'b0);
      check("t6_err", err, 1'b0);
      check("t6_result", result, 8'h00);
      check("t6_probes", probes, 4'h0);
      no_done = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (done) no_done = 1'b0;
      end
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (done || busy) no_done = 1'b0;
      end
      check("t6_no_done", no_done, 1'b1);
      run(8'h5A, 2'd0, 1'b0, 1'b0, "t6re");
      exp_q = '{8'h7F, 8'h3F, 8'h5F, 8'h4F, 8'h57, 8'h5B, 8'h59, 8'h5A};
      check_seq("t6re");
      check("t6re_found", found, 1'b1);
      check("t6re_result", result, 8'h5A);
      check("t6re_probes", probes, 4'd8);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
